// File: rtl/vram_pkg.sv
// Shared types and widths for the VRAM rectangle-fill engine.
package vram_pkg;
    localparam int PIXEL_BITS = 16;
    localparam int COORD_BITS = 8;

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} fill_state_t;

    typedef struct packed {
        logic [COORD_BITS-1:0] x;
        logic [COORD_BITS-1:0] y;
        logic [COORD_BITS-1:0] w;
        logic [COORD_BITS-1:0] h;
        logic [PIXEL_BITS-1:0] color;
    } rect_cmd_t;
endpackage

// File: rtl/vram_rect_fill_if.sv
// Command handshake and RAM write-port bundle of the rectangle-fill engine.
interface vram_rect_fill_if;
    import vram_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [COORD_BITS-1:0] cmd_x;
    logic [COORD_BITS-1:0] cmd_y;
    logic [COORD_BITS-1:0] cmd_w;
    logic [COORD_BITS-1:0] cmd_h;
    logic [PIXEL_BITS-1:0] cmd_color;
    logic [15:0]           mem_addr;
    logic [PIXEL_BITS-1:0] mem_data;
    logic                  mem_wren;
    logic                  busy;
    logic                  done;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, mem_addr, mem_data, mem_wren, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, mem_addr, mem_data, mem_wren, busy, done
    );
endinterface

// File: rtl/vram_rect_fill_clip.sv
// Clips a rectangle to the framebuffer and computes the word address of its top-left pixel.
module rect_clip
    import vram_pkg::*;
#(
    parameter logic [15:0] FB_BASE   = 16'h0000,
    parameter int          FB_WIDTH  = 160,
    parameter int          FB_HEIGHT = 120
) (
    input  logic [COORD_BITS-1:0] x,
    input  logic [COORD_BITS-1:0] y,
    input  logic [COORD_BITS-1:0] w,
    input  logic [COORD_BITS-1:0] h,
    output logic [COORD_BITS-1:0] w_eff,
    output logic [COORD_BITS-1:0] h_eff,
    output logic                  empty,
    output logic [15:0]           start_addr
);
    localparam logic [COORD_BITS-1:0] W8  = COORD_BITS'(FB_WIDTH);
    localparam logic [COORD_BITS-1:0] H8  = COORD_BITS'(FB_HEIGHT);
    localparam logic [15:0]           W16 = 16'(FB_WIDTH);

    logic [COORD_BITS-1:0] w_rem;
    logic [COORD_BITS-1:0] h_rem;

    // Remaining span is only meaningful when the origin lies inside the frame.
    assign w_rem = W8 - x;
    assign h_rem = H8 - y;

    assign empty = (w == '0) || (h == '0) ||
                   ({24'd0, x} >= 32'(FB_WIDTH)) || ({24'd0, y} >= 32'(FB_HEIGHT));

    assign w_eff = (w < w_rem) ? w : w_rem;
    assign h_eff = (h < h_rem) ? h : h_rem;

    assign start_addr = FB_BASE + (16'(y) * W16) + 16'(x);
endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine: accepts a command, clips it, then writes one framebuffer word per clock.
module vram_rect_fill
    import vram_pkg::*;
#(
    parameter logic [15:0] FB_BASE   = 16'h0000,
    parameter int          FB_WIDTH  = 160,
    parameter int          FB_HEIGHT = 120
) (
    input  logic               clock,
    input  logic               clear,
    vram_rect_fill_if.slave    bus
);
    localparam logic [15:0] W16 = 16'(FB_WIDTH);

    fill_state_t           state_q, state_d;
    rect_cmd_t             cmd_q, cmd_d;
    logic [15:0]           addr_q, addr_d;
    logic [15:0]           row_q, row_d;
    logic [PIXEL_BITS-1:0] data_q, data_d;
    logic [COORD_BITS-1:0] col_cnt_q, col_cnt_d;
    logic [COORD_BITS-1:0] row_cnt_q, row_cnt_d;
    logic [COORD_BITS-1:0] w_eff_q, w_eff_d;

    logic [COORD_BITS-1:0] clip_w, clip_h;
    logic                  clip_empty;
    logic [15:0]           clip_start;

    rect_clip #(
        .FB_BASE   (FB_BASE),
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_clip (
        .x          (cmd_q.x),
        .y          (cmd_q.y),
        .w          (cmd_q.w),
        .h          (cmd_q.h),
        .w_eff      (clip_w),
        .h_eff      (clip_h),
        .empty      (clip_empty),
        .start_addr (clip_start)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            addr_q    <= '0;
            row_q     <= '0;
            data_q    <= '0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            w_eff_q   <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            row_q     <= row_d;
            data_q    <= data_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            w_eff_q   <= w_eff_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        row_d     = row_q;
        data_d    = data_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        w_eff_d   = w_eff_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d.x     = bus.cmd_x;
                    cmd_d.y     = bus.cmd_y;
                    cmd_d.w     = bus.cmd_w;
                    cmd_d.h     = bus.cmd_h;
                    cmd_d.color = bus.cmd_color;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                // Write-port registers load only on the way into FILL, so they hold through SETUP.
                if (clip_empty) begin
                    state_d = DONE;
                end else begin
                    state_d   = FILL;
                    addr_d    = clip_start;
                    row_d     = clip_start;
                    data_d    = cmd_q.color;
                    col_cnt_d = clip_w - 1'b1;
                    row_cnt_d = clip_h - 1'b1;
                    w_eff_d   = clip_w;
                end
            end
            FILL: begin
                if (col_cnt_q != '0) begin
                    addr_d    = addr_q + 16'd1;
                    col_cnt_d = col_cnt_q - 1'b1;
                end else if (row_cnt_q != '0) begin
                    row_d     = row_q + W16;
                    addr_d    = row_q + W16;
                    col_cnt_d = w_eff_q - 1'b1;
                    row_cnt_d = row_cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the state flop directly so reset removes mem_wren without waiting for a clock.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.mem_wren  = (state_q == FILL);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_data  = data_q;
endmodule

// File: tb/tb_vram_rect_fill.sv
// Directed bench for vram_rect_fill: reset, fill, clipping, empty, back-to-back and mid-fill reset.
module tb_vram_rect_fill;
    logic clock;
    logic clear;
    int   checks;
    int   errors;

    vram_rect_fill_if bus();

    vram_rect_fill #(
        .FB_BASE   (16'h0000),
        .FB_WIDTH  (160),
        .FB_HEIGHT (120)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {cmd_ready, busy, done, mem_wren}
    function automatic logic [3:0] flags();
        return {bus.cmd_ready, bus.busy, bus.done, bus.mem_wren};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                         input logic [7:0] h, input logic [15:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_w     = w;
        bus.cmd_h     = h;
        bus.cmd_color = c;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        drive(8'd5, 8'd5, 8'd1, 8'd1, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (flags() !== 4'b1000) begin
                errors++;
                $display("FAIL reset_flags cyc%0d got %b want %b", i, flags(), 4'b1000);
            end
        end
        checks++;
        if ({bus.mem_addr, bus.mem_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got %h want %h", {bus.mem_addr, bus.mem_data}, 32'h0);
        end
        bus.cmd_valid = 1'b0;
        clear = 1'b1;
        step();
        checks++;
        if (flags() !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release got %b want %b", flags(), 4'b1000);
        end
    endtask

    task automatic test_basic_fill();
        logic [15:0] exp_addr [4];
        exp_addr = '{16'd163, 16'd164, 16'd323, 16'd324};
        drive(8'd3, 8'd1, 8'd2, 8'd2, 16'h0F00);
        step();
        bus.cmd_valid = 1'b0;
        drive(8'd50, 8'd50, 8'd9, 8'd9, 16'hBEEF);
        bus.cmd_valid = 1'b0;
        checks++;
        if (flags() !== 4'b0100) begin
            errors++;
            $display("FAIL basic_setup got %b want %b", flags(), 4'b0100);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({flags(), bus.mem_addr, bus.mem_data} !== {4'b0101, exp_addr[i], 16'h0F00}) begin
                errors++;
                $display("FAIL basic_write%0d got %b/%0d/%h want %b/%0d/%h", i,
                         flags(), bus.mem_addr, bus.mem_data, 4'b0101, exp_addr[i], 16'h0F00);
            end
        end
        step();
        checks++;
        if (flags() !== 4'b0110) begin
            errors++;
            $display("FAIL basic_done got %b want %b", flags(), 4'b0110);
        end
        step();
        checks++;
        if (flags() !== 4'b1000) begin
            errors++;
            $display("FAIL basic_idle got %b want %b", flags(), 4'b1000);
        end
    endtask

    task automatic test_clipping();
        logic [15:0] exp_addr [2];
        exp_addr = '{16'd19198, 16'd19199};
        drive(8'd158, 8'd119, 8'd5, 8'd3, 16'h00F0);
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({flags(), bus.mem_addr, bus.mem_data} !== {4'b0101, exp_addr[i], 16'h00F0}) begin
                errors++;
                $display("FAIL clip_write%0d got %b/%0d/%h want %b/%0d/%h", i,
                         flags(), bus.mem_addr, bus.mem_data, 4'b0101, exp_addr[i], 16'h00F0);
            end
        end
        step();
        checks++;
        if (flags() !== 4'b0110) begin
            errors++;
            $display("FAIL clip_done got %b want %b", flags(), 4'b0110);
        end
        step();
    endtask

    task automatic test_empty();
        logic [7:0] xs [2];
        logic [7:0] ws [2];
        xs = '{8'd5, 8'd160};
        ws = '{8'd0, 8'd4};
        for (int k = 0; k < 2; k++) begin
            drive(xs[k], 8'd5, ws[k], 8'd2, 16'h0ABC);
            step();
            bus.cmd_valid = 1'b0;
            checks++;
            if (flags() !== 4'b0100) begin
                errors++;
                $display("FAIL empty%0d_setup got %b want %b", k, flags(), 4'b0100);
            end
            step();
            checks++;
            if (flags() !== 4'b0110) begin
                errors++;
                $display("FAIL empty%0d_done got %b want %b", k, flags(), 4'b0110);
            end
            step();
            checks++;
            if (flags() !== 4'b1000) begin
                errors++;
                $display("FAIL empty%0d_idle got %b want %b", k, flags(), 4'b1000);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(8'd0, 8'd0, 8'd1, 8'd1, 16'h0111);
        step();
        drive(8'd1, 8'd0, 8'd1, 8'd1, 16'h0222);
        step();
        checks++;
        if ({flags(), bus.mem_addr, bus.mem_data} !== {4'b0101, 16'd0, 16'h0111}) begin
            errors++;
            $display("FAIL b2b_write0 got %b/%0d/%h want %b/0/0111", flags(), bus.mem_addr, bus.mem_data, 4'b0101);
        end
        step();
        checks++;
        if (flags() !== 4'b0110) begin
            errors++;
            $display("FAIL b2b_done0 got %b want %b", flags(), 4'b0110);
        end
        step();
        checks++;
        if (flags() !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_gap got %b want %b", flags(), 4'b1000);
        end
        step();
        bus.cmd_valid = 1'b0;
        checks++;
        if (flags() !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_setup1 got %b want %b", flags(), 4'b0100);
        end
        step();
        checks++;
        if ({flags(), bus.mem_addr, bus.mem_data} !== {4'b0101, 16'd1, 16'h0222}) begin
            errors++;
            $display("FAIL b2b_write1 got %b/%0d/%h want %b/1/0222", flags(), bus.mem_addr, bus.mem_data, 4'b0101);
        end
        step();
        checks++;
        if (flags() !== 4'b0110) begin
            errors++;
            $display("FAIL b2b_done1 got %b want %b", flags(), 4'b0110);
        end
        step();
    endtask

    task automatic test_reset_mid_fill();
        drive(8'd10, 8'd0, 8'd4, 8'd1, 16'h0777);
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        step();
        checks++;
        if ({bus.mem_wren, bus.mem_addr} !== {1'b1, 16'd12}) begin
            errors++;
            $display("FAIL midrst_third got %b/%0d want 1/12", bus.mem_wren, bus.mem_addr);
        end
        clear = 1'b0;
        #1;
        checks++;
        if (flags() !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_async got %b want %b", flags(), 4'b1000);
        end
        step();
        step();
        checks++;
        if (flags() !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_held got %b want %b", flags(), 4'b1000);
        end
        clear = 1'b1;
        step();
        drive(8'd0, 8'd0, 8'd1, 8'd1, 16'h0333);
        step();
        bus.cmd_valid = 1'b0;
        step();
        checks++;
        if ({flags(), bus.mem_addr, bus.mem_data} !== {4'b0101, 16'd0, 16'h0333}) begin
            errors++;
            $display("FAIL midrst_refill got %b/%0d/%h want %b/0/0333", flags(), bus.mem_addr, bus.mem_data, 4'b0101);
        end
        step();
        checks++;
        if (flags() !== 4'b0110) begin
            errors++;
            $display("FAIL midrst_done got %b want %b", flags(), 4'b0110);
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear  = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x = '0;
        bus.cmd_y = '0;
        bus.cmd_w = '0;
        bus.cmd_h = '0;
        bus.cmd_color = '0;
        #2;
        test_reset();
        test_basic_fill();
        test_clipping();
        test_empty();
        test_back_to_back();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
